// File: rtl/guvm_icache_pkg.sv
// guvm_icache_pkg: shared types and constants for the icache responder slice
package guvm_icache_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INST_DEF = 32'h01000000;
    typedef enum logic [1:0] {IDLE, MISS, SUPPLY, STARVE} state_e;
endpackage

// File: rtl/guvm_inst_fifo.sv
// guvm_inst_fifo: synchronous instruction FIFO with registered occupancy count
module guvm_inst_fifo
    import guvm_icache_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = WORD_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign rdata = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/guvm_icache_responder.sv
// guvm_icache_responder: feeds queued driver instructions to the core fetch port with miss/stall modelling
module guvm_icache_responder
    import guvm_icache_pkg::*;
#(
    parameter int                DEPTH    = 8,
    parameter int                MISS_LAT = 2,
    parameter logic [WORD_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       drv_valid,
    input  logic [WORD_W-1:0]          drv_inst,
    output logic                       drv_ready,
    input  logic                       fetch_req,
    input  logic [WORD_W-1:0]          fetch_addr,
    input  logic                       fetch_flush,
    output logic [WORD_W-1:0]          ic_data,
    output logic                       ic_hold,
    output logic                       ic_exception,
    output logic                       ic_mds,
    output logic                       mon_valid,
    output logic [WORD_W-1:0]          mon_addr,
    output logic [WORD_W-1:0]          mon_inst,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int LW = MISS_LAT > 1 ? $clog2(MISS_LAT) : 1;
    localparam logic [LW-1:0] LAT_INIT = LW'(MISS_LAT > 0 ? MISS_LAT - 1 : 0);
    state_e state, state_n;
    logic [LW-1:0] lat_cnt, lat_cnt_n;
    logic [WORD_W-1:0] addr, last_addr, head;
    logic seq_valid, miss_flag, full, empty, push, pop, accept, hit, misaligned, cont;
    guvm_inst_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(drv_inst),
        .rdata(head), .full(full), .empty(empty), .count(fifo_count)
    );
    assign drv_ready  = !full;
    assign push       = drv_valid && drv_ready;
    assign misaligned = fetch_addr[1:0] != 2'b00;
    assign hit        = (seq_valid && !fetch_flush && fetch_addr == last_addr + 32'd4) || MISS_LAT == 0;
    assign accept     = state == IDLE && fetch_req && !misaligned;
    assign pop        = (state == SUPPLY || state == STARVE) && !empty;
    // Back-to-back sequential fetches keep streaming without returning to IDLE
    assign cont       = pop && fetch_req && !fetch_flush && fetch_addr == addr + 32'd4;
    always_comb begin
        state_n   = state;
        lat_cnt_n = lat_cnt;
        unique case (state)
            IDLE: if (accept) begin
                state_n   = hit ? SUPPLY : MISS;
                lat_cnt_n = LAT_INIT;
            end
            MISS: begin
                state_n   = lat_cnt == '0 ? SUPPLY : MISS;
                lat_cnt_n = lat_cnt == '0 ? lat_cnt : lat_cnt - LW'(1);
            end
            SUPPLY, STARVE: state_n = pop ? (cont ? SUPPLY : IDLE) : STARVE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            addr         <= '0;
            last_addr    <= '0;
            seq_valid    <= 1'b0;
            miss_flag    <= 1'b0;
            ic_data      <= NOP_INST;
            ic_hold      <= 1'b1;
            ic_exception <= 1'b0;
            ic_mds       <= 1'b0;
            mon_valid    <= 1'b0;
            mon_addr     <= '0;
            mon_inst     <= '0;
        end else begin
            state        <= state_n;
            lat_cnt      <= lat_cnt_n;
            if (accept || cont) addr <= fetch_addr;
            if (pop) last_addr <= addr;
            seq_valid    <= !fetch_flush && (pop || seq_valid);
            miss_flag    <= accept ? !hit : pop ? 1'b0 : miss_flag;
            ic_data      <= pop ? head : NOP_INST;
            ic_hold      <= !(state_n == MISS || state_n == STARVE);
            ic_exception <= state == IDLE && fetch_req && misaligned;
            ic_mds       <= pop && miss_flag;
            mon_valid    <= pop;
            if (pop) begin
                mon_addr <= addr;
                mon_inst <= head;
            end
        end
    end
endmodule
